// File: rtl/bgr_pkg.sv
// rtl/bgr_pkg.sv - state enum, default parameters and width helper for bgr_startup_ctrl
package bgr_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    KICK   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    READY  = 3'd4,
    FAULT  = 3'd5
  } bgr_state_e;

  localparam int unsigned DEF_PULSE_CYCLES  = 16;
  localparam int unsigned DEF_SETTLE_CYCLES = 1024;
  localparam int unsigned DEF_OK_FILTER     = 4;
  localparam int unsigned DEF_MAX_RETRY     = 3;

  // Keeps a port at least one bit wide when MAX_RETRY is 0.
  function automatic int unsigned bgr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bgr_sync2.sv
// rtl/bgr_sync2.sv - two-flop synchronizer for the asynchronous bgr_ok comparator flag
module bgr_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/bgr_startup_ctrl.sv
// rtl/bgr_startup_ctrl.sv - bandgap start-up kick/settle/check sequencer.
// Retry on failed check or READY dropout is enabled by defining BGR_STARTUP_RETRY_EN.
module bgr_startup_ctrl
  import bgr_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned OK_FILTER     = DEF_OK_FILTER,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  bgr_ok,
  output logic                                  porst,
  output logic                                  bgr_ready,
  output logic                                  fault,
  output logic [bgr_width(MAX_RETRY + 1)-1:0]   retry_cnt
);

  localparam int unsigned TMR_LIM = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_LIM) + 1;
  localparam int unsigned FLT_W   = $clog2(OK_FILTER) + 1;
  localparam int unsigned RTY_W   = bgr_width(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_SAT     = TMR_W'(TMR_LIM);
  localparam logic [FLT_W-1:0] FLT_LAST    = FLT_W'(OK_FILTER - 1);
  localparam logic [FLT_W-1:0] FLT_SAT     = FLT_W'(OK_FILTER);
`ifdef BGR_STARTUP_RETRY_EN
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRY);
`endif

  logic ok_s;

  bgr_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [FLT_W-1:0] flt_q, flt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             porst_q, porst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  bgr_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bgr_ok),
    .q     (ok_s)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    flt_d   = flt_q;
    retry_d = retry_q;

    if (!en) begin
      state_d = OFF;
      tmr_d   = '0;
      flt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = KICK;
          tmr_d   = '0;
          flt_d   = '0;
        end
        KICK: begin
          if (tmr_q >= PULSE_LAST) begin
            state_d = SETTLE;
            tmr_d   = '0;
          end else begin
            tmr_d = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + 1'b1;
          end
        end
        SETTLE: begin
          if (tmr_q >= SETTLE_LAST) begin
            state_d = CHECK;
            tmr_d   = '0;
            flt_d   = '0;
          end else begin
            tmr_d = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + 1'b1;
          end
        end
        CHECK: begin
          if (ok_s) begin
            if (flt_q >= FLT_LAST) begin
              state_d = READY;
              flt_d   = '0;
            end else begin
              flt_d = (flt_q == FLT_SAT) ? flt_q : flt_q + 1'b1;
            end
          end else begin
            // A single low sample during the check window is a failed check.
            flt_d = '0;
            tmr_d = '0;
`ifdef BGR_STARTUP_RETRY_EN
            if (retry_q < RTY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = KICK;
            end else begin
              state_d = FAULT;
            end
`else
            state_d = FAULT;
`endif
          end
        end
        READY: begin
          if (!ok_s) begin
            if (flt_q >= FLT_LAST) begin
              flt_d = '0;
              tmr_d = '0;
`ifdef BGR_STARTUP_RETRY_EN
              retry_d = '0;
              state_d = KICK;
`else
              state_d = FAULT;
`endif
            end else begin
              flt_d = (flt_q == FLT_SAT) ? flt_q : flt_q + 1'b1;
            end
          end else begin
            flt_d = '0;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = OFF;
        end
      endcase
    end

    porst_d = (state_d == KICK);
    ready_d = (state_d == READY);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      tmr_q   <= '0;
      flt_q   <= '0;
      retry_q <= '0;
      porst_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      flt_q   <= flt_d;
      retry_q <= retry_d;
      porst_q <= porst_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign porst     = porst_q;
  assign bgr_ready = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: doc/bgr_startup_ctrl.md
BGR_STARTUP_CTRL -- requirements
Module: bgr_startup_ctrl

Interface
REQ-001 Parameter PULSE_CYCLES, default 16: width of the porst start-up kick in clk cycles (>=1).
REQ-002 Parameter SETTLE_CYCLES, default 1024: wait after the kick before vbg is checked (>=1).
REQ-003 Parameter OK_FILTER, default 4: consecutive synchronized bgr_ok samples needed to change the decision (>=1).
REQ-004 Parameter MAX_RETRY, default 3: kick retries allowed after the first failed check (>=0).
REQ-005 The port list SHALL be as follows.
- clk  input  1: single clock.
- rst_n  input  1: asynchronous, active-low reset.
- en  input  1: bandgap enable, synchronous to clk.
- bgr_ok  input  1: asynchronous comparator flag, high while vbg is within its window.
- porst  output  1: start-up kick to the nfet gate that pulls vc low; registered.
- bgr_ready  output  1: vbg valid; registered.
- fault  output  1: start-up failed; sticky; registered.
- retry_cnt  output  $clog2(MAX_RETRY+1)  retries used since the last en rise.

Function
REQ-006 bgr_ok SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (ok_s).
REQ-007 FSM states SHALL be OFF, KICK, SETTLE, CHECK, READY and FAULT.
REQ-008 OFF: all outputs are 0. en=1 SHALL move the FSM to KICK on the next edge.
REQ-009 KICK: porst=1 for exactly PULSE_CYCLES cycles, starting the cycle after en is sampled high; then SETTLE.
REQ-010 SETTLE: porst=0; count SETTLE_CYCLES cycles, then CHECK.
REQ-011 CHECK: OK_FILTER consecutive ok_s=1 SHALL move the FSM to READY; bgr_ready=1 from the following cycle.
REQ-012 CHECK: any ok_s=0 SHALL count as a failed check.
- If retry_cnt<MAX_RETRY: retry_cnt increments and the FSM goes to KICK.
- Otherwise: the FSM goes to FAULT.
REQ-013 READY: bgr_ready=1. OK_FILTER consecutive ok_s=0 SHALL clear bgr_ready, clear retry_cnt and move the FSM to KICK. A shorter dropout SHALL be ignored.
REQ-014 FAULT: fault=1, porst=0, bgr_ready=0. The FSM leaves only via en=0 or reset.
REQ-015 en=0 in any state SHALL force OFF on the next edge: porst, bgr_ready and fault cleared; all counters and retry_cnt cleared.
REQ-016 en re-asserted in the same cycle the FSM reaches OFF SHALL start a fresh KICK on the following edge.
REQ-017 Counters SHALL saturate, never wrap. Each counter is sized $clog2 of its limit plus 1.

Reset
REQ-018 rst_n=0 SHALL asynchronously force:
- the FSM to OFF;
- porst=0, bgr_ready=0, fault=0;
- retry_cnt=0, all counters=0;
- synchronizer flops=0.
REQ-019 Deassertion SHALL be used as-is (synchronized upstream). The first kick needs en high after release.

Configuration
REQ-020 Macro BGR_STARTUP_RETRY_EN:
- Defined: retry behaviour per REQ-012 and REQ-013.
- Undefined: any failed check goes straight to FAULT; a READY dropout goes to FAULT; retry_cnt is tied to 0.

Structure
REQ-021 Shared package bgr_pkg SHALL hold the state enum (bgr_state_e) and the default parameter constants.
REQ-022 The synchronizer SHALL be the sub-module bgr_sync2 (1-bit, async active-low reset).

Verification (PULSE=4, SETTLE=16, FILTER=2, MAX_RETRY=2, retry macro on unless stated)
REQ-023 Nominal start-up.
- Stimulus: en rises at cycle 0; bgr_ok held 1.
- Response: porst=1 in cycles 1-4; CHECK from cycle 21; bgr_ready=1 by cycle 24; fault=0.
REQ-024 Retry exhaustion.
- Stimulus: bgr_ok held 0.
- Response: three kicks of 4 cycles each; retry_cnt reaches 2; then fault=1, bgr_ready=0.
REQ-025 Dropout filter.
- Stimulus in READY: a 1-cycle bgr_ok glitch low.
  Response: bgr_ready stays 1.
- Stimulus in READY: a 3-cycle bgr_ok low.
  Response: bgr_ready drops, new 4-cycle porst pulse, retry_cnt=0.
REQ-026 Disable mid-kick.
- Stimulus: en=0 in cycle 2 of KICK.
- Response: porst=0 next cycle, FSM in OFF; after en=1, a full 4-cycle pulse.
REQ-027 Reset mid-operation.
- Stimulus: rst_n pulsed low in SETTLE and in FAULT.
- Response: all outputs 0 immediately, without waiting for a clk edge.
REQ-028 Macro off.
- Stimulus: bgr_ok held 0.
- Response: a single kick, then fault=1 after the first failed check; retry_cnt=0 throughout.
